// File: rtl/ram_io_responder_pkg.sv
// Shared constants for the RAM/IO responder: IO window addresses, status bits, address decode.
package ram_io_responder_pkg;

    localparam int          IO_BIT       = 17;
    localparam logic [31:0] IO_TX        = 32'h0003_0000;
    localparam logic [31:0] IO_HALT      = 32'h0003_0004;
    localparam int          STAT_TX_FULL = 0;
    localparam int          STAT_RX_NE   = 1;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_TX,
        SEL_HALT,
        SEL_OTHER
    } io_sel_e;

    // Only the IO bit and the bits below it take part in the decode.
    function automatic io_sel_e decode_addr(input logic [IO_BIT:0] a);
        if (!a[IO_BIT]) begin
            return SEL_RAM;
        end else if (a == IO_TX[IO_BIT:0]) begin
            return SEL_TX;
        end else if (a == IO_HALT[IO_BIT:0]) begin
            return SEL_HALT;
        end else begin
            return SEL_OTHER;
        end
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte-wide FIFO with occupancy count; a push into a full FIFO succeeds only with a same-cycle pop.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          drop
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full       = (count_reg == CW'(DEPTH));
    assign empty      = (count_reg == '0);
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign drop       = push && full && !do_pop;
    assign count      = count_reg;
    assign count_next = count_reg + CW'(do_push) - CW'(do_pop);
    assign pop_data   = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth: pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Byte-bus responder: RAM with 1-cycle read latency, IO window with TX FIFO, halt flag and status.
// Optional host input FIFO readable at IO_TX is enabled with `define IO_RX_EN.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_AW     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] mem_a_in,
    input  logic [7:0]  mem_d_in,
    input  logic        mem_wr_in,
    output logic [7:0]  mem_d_out,
    output logic        rdy_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_done,
    output logic        tx_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    io_sel_e       sel;
    logic          wr_tx;
    logic          rd_tx;
    logic          wr_halt;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_drop;
    logic [CW-1:0] tx_count_next;
    logic [CW-1:0] unused_tx_count;
    logic          rx_nonempty;
    logic [7:0]    rx_rd_byte;
    logic [7:0]    status;
    logic [7:0]    io_rdata_next;
    logic          unused_addr;

    logic [7:0]    ram_mem [2**RAM_AW];
    logic [7:0]    ram_rdata_reg;
    logic          sel_ram_reg;
    logic [7:0]    io_rdata_reg;
    logic          rdy_reg;
    logic          sim_done_reg;
    logic          tx_ovf_reg;

    assign sel         = decode_addr(mem_a_in[IO_BIT:0]);
    assign wr_tx       = mem_wr_in && (sel == SEL_TX);
    assign rd_tx       = !mem_wr_in && (sel == SEL_TX);
    assign wr_halt     = mem_wr_in && (sel == SEL_HALT);
    assign unused_addr = &{1'b0, mem_a_in};

    always_ff @(posedge clk_in) begin
        if (sel == SEL_RAM) begin
            if (mem_wr_in) begin
                ram_mem[mem_a_in[RAM_AW-1:0]] <= mem_d_in;
            end else begin
                ram_rdata_reg <= ram_mem[mem_a_in[RAM_AW-1:0]];
            end
        end
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .push       (wr_tx),
        .push_data  (mem_d_in),
        .pop        (tx_ready),
        .pop_data   (tx_data),
        .full       (tx_full),
        .empty      (tx_empty),
        .count      (unused_tx_count),
        .count_next (tx_count_next),
        .drop       (tx_drop)
    );

    assign tx_valid = !tx_empty;

`ifdef IO_RX_EN
    logic          rx_full;
    logic          rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] unused_rx_count;
    logic [CW-1:0] unused_rx_count_next;
    logic          unused_rx_drop;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .push       (rx_valid),
        .push_data  (rx_data),
        .pop        (rd_tx),
        .pop_data   (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .count      (unused_rx_count),
        .count_next (unused_rx_count_next),
        .drop       (unused_rx_drop)
    );

    assign rx_ready    = !rx_full;
    assign rx_nonempty = !rx_empty;
    assign rx_rd_byte  = rx_empty ? 8'h00 : rx_head;
`else
    logic unused_rx;

    assign unused_rx   = &{1'b0, rx_data, rx_valid, rd_tx};
    assign rx_ready    = 1'b0;
    assign rx_nonempty = 1'b0;
    assign rx_rd_byte  = 8'h00;
`endif

    always_comb begin
        status               = '0;
        status[STAT_TX_FULL] = tx_full;
        status[STAT_RX_NE]   = rx_nonempty;
    end

    always_comb begin
        io_rdata_next = '0;
        if (!mem_wr_in) begin
            case (sel)
                SEL_TX:   io_rdata_next = rx_rd_byte;
                SEL_HALT: io_rdata_next = status;
                default:  io_rdata_next = '0;
            endcase
        end
    end

    // Stall as soon as occupancy reaches DEPTH-1 so the write already in flight still fits.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_ram_reg  <= 1'b0;
            io_rdata_reg <= '0;
            rdy_reg      <= 1'b1;
            sim_done_reg <= 1'b0;
            tx_ovf_reg   <= 1'b0;
        end else begin
            sel_ram_reg  <= (sel == SEL_RAM) && !mem_wr_in;
            io_rdata_reg <= io_rdata_next;
            rdy_reg      <= (tx_count_next < CW'(FIFO_DEPTH - 1));
            if (wr_halt) sim_done_reg <= 1'b1;
            if (tx_drop) tx_ovf_reg   <= 1'b1;
        end
    end

    assign mem_d_out = sel_ram_reg ? ram_rdata_reg : io_rdata_reg;
    assign rdy_out   = rdy_reg;
    assign sim_done  = sim_done_reg;
    assign tx_ovf    = tx_ovf_reg;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed self-checking bench for ram_io_responder (default DEPTH 8, RAM_AW 17).
module tb_ram_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [31:0] mem_a_in;
    logic [7:0]  mem_d_in;
    logic        mem_wr_in;
    logic [7:0]  mem_d_out;
    logic        rdy_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        sim_done;
    logic        tx_ovf;

    int checks   = 0;
    int failures = 0;

    ram_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .mem_a_in  (mem_a_in),
        .mem_d_in  (mem_d_in),
        .mem_wr_in (mem_wr_in),
        .mem_d_out (mem_d_out),
        .rdy_out   (rdy_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .sim_done  (sim_done),
        .tx_ovf    (tx_ovf)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Present one bus cycle, then sample 1 time unit after the edge that consumes it.
    task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic wr);
        mem_a_in  = a;
        mem_d_in  = d;
        mem_wr_in = wr;
        @(posedge clk_in);
        #1;
    endtask

    logic [7:0] drain_exp [8];
    int         model_cnt;

    initial begin
        rst_n_in  = 1'b0;
        mem_a_in  = '0;
        mem_d_in  = '0;
        mem_wr_in = 1'b0;
        tx_ready  = 1'b0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_mem_d_out", mem_d_out, 0);
        check("rst_rdy", rdy_out, 1);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_sim_done", sim_done, 0);
        check("rst_tx_ovf", tx_ovf, 0);
`ifdef IO_RX_EN
        check("rst_rx_ready", rx_ready, 1);
`else
        check("rst_rx_ready", rx_ready, 0);
`endif
        rst_n_in = 1'b1;

        // RAM write/read, including the top byte of the array
        bus(32'h0001_0, 8'hA5, 1'b1);
        check("ram_wr_rdata0", mem_d_out, 0);
        bus(32'h0001_0, 8'h00, 1'b0);
        check("ram_rd_a5", mem_d_out, 8'hA5);
        bus(32'h0001_FFFF, 8'h3C, 1'b1);
        bus(32'h0001_0, 8'h5A, 1'b1);
        bus(32'h0001_FFFF, 8'h00, 1'b0);
        check("ram_rd_top", mem_d_out, 8'h3C);
        bus(32'h0001_0, 8'h00, 1'b0);
        check("ram_raw_5a", mem_d_out, 8'h5A);

        // "Hi" through the TX FIFO
        bus(32'h0003_0000, 8'h48, 1'b1);
        bus(32'h0003_0000, 8'h69, 1'b1);
        check("hi_valid", tx_valid, 1);
        check("hi_head_h", tx_data, 8'h48);
        tx_ready = 1'b1;
        bus(32'h0, 8'h00, 1'b0);
        check("hi_head_i", tx_data, 8'h69);
        bus(32'h0, 8'h00, 1'b0);
        check("hi_drained", tx_valid, 0);
        tx_ready = 1'b0;

        // Fill to full with rdy_out falling after the 7th write
        for (int i = 1; i <= 8; i++) begin
            bus(32'h0003_0000, 8'(i), 1'b1);
            if (i == 6) check("fill6_rdy", rdy_out, 1);
            if (i == 7) check("fill7_rdy", rdy_out, 0);
        end
        check("fill8_ovf", tx_ovf, 0);
        check("fill8_head", tx_data, 8'h01);
        bus(32'h0003_0004, 8'h00, 1'b0);
        check("status_full", mem_d_out, 8'h01);

        // Push and pop on a full FIFO in the same cycle
        tx_ready = 1'b1;
        bus(32'h0003_0000, 8'hAA, 1'b1);
        tx_ready = 1'b0;
        check("pushpop_ovf", tx_ovf, 0);
        check("pushpop_head", tx_data, 8'h02);
        check("pushpop_rdy", rdy_out, 0);

        // Overflow drop
        bus(32'h0003_0000, 8'h09, 1'b1);
        check("ovf_set", tx_ovf, 1);
        bus(32'h0, 8'h00, 1'b0);

        // Drain, order preserved and the dropped byte absent
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        model_cnt = 8;
        tx_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), tx_valid, 1);
            check($sformatf("drain%0d_data", i), tx_data, drain_exp[i]);
            bus(32'h0, 8'h00, 1'b0);
            model_cnt--;
            check($sformatf("drain%0d_rdy", i), rdy_out, (model_cnt < 7) ? 1 : 0);
        end
        check("drain_empty", tx_valid, 0);
        tx_ready = 1'b0;

        // Halt flag, status and unmapped IO
        bus(32'h0003_0004, 8'h00, 1'b1);
        check("halt_set", sim_done, 1);
        bus(32'h0003_0004, 8'h00, 1'b0);
        check("status_empty", mem_d_out, 8'h00);
        bus(32'h0003_0008, 8'h77, 1'b1);
        check("io_other_wr", tx_valid, 0);
        bus(32'h0001_0, 8'h00, 1'b0);
        bus(32'h0003_0008, 8'h00, 1'b0);
        check("io_other_rd", mem_d_out, 8'h00);

`ifdef IO_RX_EN
        rx_data  = 8'h7A;
        rx_valid = 1'b1;
        bus(32'h0, 8'h00, 1'b0);
        rx_valid = 1'b0;
        bus(32'h0003_0004, 8'h00, 1'b0);
        check("rx_status", mem_d_out, 8'h02);
        bus(32'h0003_0000, 8'h00, 1'b0);
        check("rx_read", mem_d_out, 8'h7A);
        bus(32'h0003_0000, 8'h00, 1'b0);
        check("rx_read_empty", mem_d_out, 8'h00);
`else
        rx_data  = 8'h7A;
        rx_valid = 1'b1;
        bus(32'h0, 8'h00, 1'b0);
        rx_valid = 1'b0;
        bus(32'h0003_0000, 8'h00, 1'b0);
        check("tx_read_norx", mem_d_out, 8'h00);
`endif

        // Reset in the middle of a drain
        for (int i = 0; i < 3; i++) bus(32'h0003_0000, 8'(8'h30 + i), 1'b1);
        tx_ready = 1'b1;
        bus(32'h0001_0, 8'h00, 1'b0);
        check("pre_rst_rd", mem_d_out, 8'h5A);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_rdy", rdy_out, 1);
        check("mid_rst_sim_done", sim_done, 0);
        check("mid_rst_tx_ovf", tx_ovf, 0);
        check("mid_rst_mem_d_out", mem_d_out, 0);
        tx_ready = 1'b0;
        @(posedge clk_in);
        #3;
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        bus(32'h0001_0, 8'h00, 1'b0);
        check("ram_kept", mem_d_out, 8'h5A);
        check("post_rst_tx_valid", tx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
